// File: rtl/lsu_agu.sv
// Load/store address-generation stage: computes rs1+imm, formats the LSU command,
// holds it for the two-cycle access and returns the result through a wbck handshake.
module lsu_agu #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disp_i_valid,
    output logic                disp_o_ready,
    input  logic                disp_i_load,
    input  logic                disp_i_store,
    input  logic [2:0]          disp_i_funct3,
    input  logic [XLEN-1:0]     disp_i_rs1,
    input  logic [XLEN-1:0]     disp_i_imm,
    input  logic [XLEN-1:0]     disp_i_rs2,
    input  logic [4:0]          disp_i_rd_idx,
    output logic                agu_o_cmd_enable,
    output logic                agu_o_cmd_read,
    output logic                agu_o_cmd_write,
    output logic                agu_o_cmd_usign,
    output logic [1:0]          agu_o_cmd_size,
    output logic [XLEN-1:0]     agu_o_cmd_addr,
    output logic [XLEN-1:0]     agu_o_cmd_wdata,
    output logic [XLEN/8-1:0]   agu_o_cmd_wmask,
    output logic                agu_o_cmd_misalgn,
    input  logic [XLEN-1:0]     lsu_i_wbck_wdata,
    input  logic                lsu_i_wbck_err,
    output logic                wbck_o_valid,
    input  logic                wbck_i_ready,
    output logic [XLEN-1:0]     wbck_o_wdata,
    output logic [4:0]          wbck_o_rd_idx,
    output logic                wbck_o_rdwen,
    output logic                wbck_o_err,
    output logic [XLEN-1:0]     wbck_o_badaddr
);

    localparam int MW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        WBCK = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0] r_cmd_addr;
    logic [XLEN-1:0] r_cmd_wdata;
    logic [MW-1:0]   r_cmd_wmask;
    logic [1:0]      r_cmd_size;
    logic            r_cmd_read;
    logic            r_cmd_write;
    logic            r_cmd_usign;
    logic            r_cmd_misalgn;
    logic [4:0]      r_rd_idx;
    logic            r_err;
    logic            r_rdwen;
    logic [XLEN-1:0] r_wbck_wdata;
    logic [XLEN-1:0] r_badaddr;

    logic [XLEN-1:0] w_addr;
    logic [1:0]      w_size;
    logic            w_illegal;
    logic            w_misalgn;
    logic            w_accept;
    logic            w_err_fin;
    logic [XLEN-1:0] w_wdata;
    logic [MW-1:0]   w_wmask;

    assign w_addr    = disp_i_rs1 + disp_i_imm;
    assign w_size    = disp_i_funct3[1:0];
    assign w_illegal = (disp_i_funct3 == 3'b011) || (disp_i_funct3[2:1] == 2'b11)
                       || (disp_i_store && disp_i_funct3[2]);
    assign w_misalgn = w_illegal
                       || ((w_size == 2'b01) && w_addr[0])
                       || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
    // Only a clean load-xor-store is taken; both/neither is consumed and dropped.
    assign w_accept  = (r_state == IDLE) && disp_i_valid && (disp_i_load ^ disp_i_store);
    assign w_err_fin = r_err | lsu_i_wbck_err;

    // Store data lane replication and byte-enable generation.
    always_comb begin
        w_wdata = {XLEN{1'b0}};
        w_wmask = {MW{1'b0}};
        if (disp_i_store && !w_misalgn) begin
            case (w_size)
                2'b00: begin
                    w_wdata = {MW{disp_i_rs2[7:0]}};
                    w_wmask = {{(MW-1){1'b0}}, 1'b1} << w_addr[1:0];
                end
                2'b01: begin
                    w_wdata = {(MW/2){disp_i_rs2[15:0]}};
                    w_wmask = w_addr[1] ? MW'(4'b1100) : MW'(4'b0011);
                end
                2'b10: begin
                    w_wdata = disp_i_rs2;
                    w_wmask = {MW{1'b1}};
                end
                default: begin
                    w_wdata = {XLEN{1'b0}};
                    w_wmask = {MW{1'b0}};
                end
            endcase
        end else begin
            w_wdata = {XLEN{1'b0}};
            w_wmask = {MW{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_misalgn ? WBCK : ACC1;
                end else begin
                    w_next = IDLE;
                end
            end
            ACC1: w_next = ACC2;
            ACC2: w_next = WBCK;
            WBCK: begin
                if (wbck_i_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = WBCK;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state decode for the handshake and enable outputs.
    always_comb begin
        disp_o_ready     = 1'b0;
        agu_o_cmd_enable = 1'b0;
        wbck_o_valid     = 1'b0;
        case (r_state)
            IDLE:    disp_o_ready     = 1'b1;
            ACC1:    agu_o_cmd_enable = 1'b1;
            ACC2:    agu_o_cmd_enable = 1'b1;
            WBCK:    wbck_o_valid     = 1'b1;
            default: disp_o_ready     = 1'b0;
        endcase
    end

    // Command capture on accept, result capture at the end of the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_addr    <= {XLEN{1'b0}};
            r_cmd_wdata   <= {XLEN{1'b0}};
            r_cmd_wmask   <= {MW{1'b0}};
            r_cmd_size    <= 2'b00;
            r_cmd_read    <= 1'b0;
            r_cmd_write   <= 1'b0;
            r_cmd_usign   <= 1'b0;
            r_cmd_misalgn <= 1'b0;
            r_rd_idx      <= 5'd0;
            r_err         <= 1'b0;
            r_rdwen       <= 1'b0;
            r_wbck_wdata  <= {XLEN{1'b0}};
            r_badaddr     <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_cmd_addr    <= w_addr;
            r_cmd_wdata   <= w_wdata;
            r_cmd_wmask   <= w_wmask;
            r_cmd_size    <= w_size;
            r_cmd_read    <= disp_i_load;
            r_cmd_write   <= disp_i_store;
            r_cmd_usign   <= disp_i_funct3[2];
            r_cmd_misalgn <= w_misalgn;
            r_rd_idx      <= disp_i_rd_idx;
            r_err         <= w_misalgn;
            r_rdwen       <= 1'b0;
            r_wbck_wdata  <= {XLEN{1'b0}};
            r_badaddr     <= w_misalgn ? w_addr : {XLEN{1'b0}};
        end else if (r_state == ACC2) begin
            r_err         <= w_err_fin;
            r_rdwen       <= r_cmd_read && !w_err_fin && (r_rd_idx != 5'd0);
            r_wbck_wdata  <= (r_cmd_read && !w_err_fin) ? lsu_i_wbck_wdata : {XLEN{1'b0}};
            r_badaddr     <= w_err_fin ? r_cmd_addr : {XLEN{1'b0}};
        end
    end

    assign agu_o_cmd_read    = r_cmd_read;
    assign agu_o_cmd_write   = r_cmd_write;
    assign agu_o_cmd_usign   = r_cmd_usign;
    assign agu_o_cmd_size    = r_cmd_size;
    assign agu_o_cmd_addr    = r_cmd_addr;
    assign agu_o_cmd_wdata   = r_cmd_wdata;
    assign agu_o_cmd_wmask   = r_cmd_wmask;
    assign agu_o_cmd_misalgn = r_cmd_misalgn;
    assign wbck_o_wdata      = r_wbck_wdata;
    assign wbck_o_rd_idx     = r_rd_idx;
    assign wbck_o_rdwen      = r_rdwen;
    assign wbck_o_err        = r_err;
    assign wbck_o_badaddr    = r_badaddr;

endmodule

// File: tb/tb_lsu_agu.sv
// Directed bench for lsu_agu: hand-computed vectors checked with immediate assertions
// one time unit after each rising clock edge.
module tb_lsu_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_i_valid;
    logic        disp_o_ready;
    logic        disp_i_load;
    logic        disp_i_store;
    logic [2:0]  disp_i_funct3;
    logic [31:0] disp_i_rs1;
    logic [31:0] disp_i_imm;
    logic [31:0] disp_i_rs2;
    logic [4:0]  disp_i_rd_idx;
    logic        agu_o_cmd_enable;
    logic        agu_o_cmd_read;
    logic        agu_o_cmd_write;
    logic        agu_o_cmd_usign;
    logic [1:0]  agu_o_cmd_size;
    logic [31:0] agu_o_cmd_addr;
    logic [31:0] agu_o_cmd_wdata;
    logic [3:0]  agu_o_cmd_wmask;
    logic        agu_o_cmd_misalgn;
    logic [31:0] lsu_i_wbck_wdata;
    logic        lsu_i_wbck_err;
    logic        wbck_o_valid;
    logic        wbck_i_ready;
    logic [31:0] wbck_o_wdata;
    logic [4:0]  wbck_o_rd_idx;
    logic        wbck_o_rdwen;
    logic        wbck_o_err;
    logic [31:0] wbck_o_badaddr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_agu #(.XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_i_valid      (disp_i_valid),
        .disp_o_ready      (disp_o_ready),
        .disp_i_load       (disp_i_load),
        .disp_i_store      (disp_i_store),
        .disp_i_funct3     (disp_i_funct3),
        .disp_i_rs1        (disp_i_rs1),
        .disp_i_imm        (disp_i_imm),
        .disp_i_rs2        (disp_i_rs2),
        .disp_i_rd_idx     (disp_i_rd_idx),
        .agu_o_cmd_enable  (agu_o_cmd_enable),
        .agu_o_cmd_read    (agu_o_cmd_read),
        .agu_o_cmd_write   (agu_o_cmd_write),
        .agu_o_cmd_usign   (agu_o_cmd_usign),
        .agu_o_cmd_size    (agu_o_cmd_size),
        .agu_o_cmd_addr    (agu_o_cmd_addr),
        .agu_o_cmd_wdata   (agu_o_cmd_wdata),
        .agu_o_cmd_wmask   (agu_o_cmd_wmask),
        .agu_o_cmd_misalgn (agu_o_cmd_misalgn),
        .lsu_i_wbck_wdata  (lsu_i_wbck_wdata),
        .lsu_i_wbck_err    (lsu_i_wbck_err),
        .wbck_o_valid      (wbck_o_valid),
        .wbck_i_ready      (wbck_i_ready),
        .wbck_o_wdata      (wbck_o_wdata),
        .wbck_o_rd_idx     (wbck_o_rd_idx),
        .wbck_o_rdwen      (wbck_o_rdwen),
        .wbck_o_err        (wbck_o_err),
        .wbck_o_badaddr    (wbck_o_badaddr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accept edge, then withdraw it.
    task automatic disp(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [31:0] rs2, input logic [4:0] rd);
        disp_i_valid  = 1'b1;
        disp_i_load   = ld;
        disp_i_store  = st;
        disp_i_funct3 = f3;
        disp_i_rs1    = rs1;
        disp_i_imm    = imm;
        disp_i_rs2    = rs2;
        disp_i_rd_idx = rd;
        tick();
        disp_i_valid  = 1'b0;
    endtask

    task automatic chk_cleared(input string pfx);
        chk({pfx, ".ready"},   32'(disp_o_ready), 32'd1);
        chk({pfx, ".en"},      32'(agu_o_cmd_enable), 32'd0);
        chk({pfx, ".valid"},   32'(wbck_o_valid), 32'd0);
        chk({pfx, ".rdwr"},    {30'd0, agu_o_cmd_read, agu_o_cmd_write}, 32'd0);
        chk({pfx, ".addr"},    agu_o_cmd_addr, 32'd0);
        chk({pfx, ".cwdata"},  agu_o_cmd_wdata, 32'd0);
        chk({pfx, ".wmask"},   32'(agu_o_cmd_wmask), 32'd0);
        chk({pfx, ".misalgn"}, 32'(agu_o_cmd_misalgn), 32'd0);
        chk({pfx, ".wwdata"},  wbck_o_wdata, 32'd0);
        chk({pfx, ".flags"},   {30'd0, wbck_o_rdwen, wbck_o_err}, 32'd0);
        chk({pfx, ".badaddr"}, wbck_o_badaddr, 32'd0);
        chk({pfx, ".rd"},      32'(wbck_o_rd_idx), 32'd0);
    endtask

    initial begin
        rst = 1'b1; disp_i_valid = 1'b0; disp_i_load = 1'b0; disp_i_store = 1'b0;
        disp_i_funct3 = 3'd0; disp_i_rs1 = 32'd0; disp_i_imm = 32'd0; disp_i_rs2 = 32'd0;
        disp_i_rd_idx = 5'd0; lsu_i_wbck_wdata = 32'd0; lsu_i_wbck_err = 1'b0;
        wbck_i_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_cleared("reset");

        // lw x5, 4(0x100)
        disp(1'b1, 1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 5'd5);
        chk("lw.acc1.en", 32'(agu_o_cmd_enable), 32'd1);
        chk("lw.acc1.valid", 32'(wbck_o_valid), 32'd0);
        chk("lw.acc1.ready", 32'(disp_o_ready), 32'd0);
        chk("lw.acc1.addr", agu_o_cmd_addr, 32'h104);
        chk("lw.acc1.size", 32'(agu_o_cmd_size), 32'd2);
        chk("lw.acc1.rdwr", {30'd0, agu_o_cmd_read, agu_o_cmd_write}, 32'd2);
        chk("lw.acc1.wmask", 32'(agu_o_cmd_wmask), 32'd0);
        lsu_i_wbck_wdata = 32'h1111_1111;
        tick();
        chk("lw.acc2.en", 32'(agu_o_cmd_enable), 32'd1);
        chk("lw.acc2.addr", agu_o_cmd_addr, 32'h104);
        lsu_i_wbck_wdata = 32'hDEAD_BEEF;
        tick();
        chk("lw.wb.en", 32'(agu_o_cmd_enable), 32'd0);
        chk("lw.wb.valid", 32'(wbck_o_valid), 32'd1);
        chk("lw.wb.wdata", wbck_o_wdata, 32'hDEAD_BEEF);
        chk("lw.wb.rd", 32'(wbck_o_rd_idx), 32'd5);
        chk("lw.wb.flags", {30'd0, wbck_o_rdwen, wbck_o_err}, 32'd2);
        chk("lw.wb.badaddr", wbck_o_badaddr, 32'd0);
        wbck_i_ready = 1'b1;
        lsu_i_wbck_wdata = 32'd0;
        tick();
        wbck_i_ready = 1'b0;
        chk("lw.idle.valid", 32'(wbck_o_valid), 32'd0);
        chk("lw.idle.ready", 32'(disp_o_ready), 32'd1);

        // sb to 0x203
        disp(1'b0, 1'b1, 3'b000, 32'h203, 32'd0, 32'h0000_00A5, 5'd7);
        chk("sb.acc1.en", 32'(agu_o_cmd_enable), 32'd1);
        chk("sb.acc1.rdwr", {30'd0, agu_o_cmd_read, agu_o_cmd_write}, 32'd1);
        chk("sb.acc1.wdata", agu_o_cmd_wdata, 32'hA5A5_A5A5);
        chk("sb.acc1.wmask", 32'(agu_o_cmd_wmask), 32'h8);
        chk("sb.acc1.addr", agu_o_cmd_addr, 32'h203);
        lsu_i_wbck_wdata = 32'h1234_5678;
        tick();
        chk("sb.acc2.en", 32'(agu_o_cmd_enable), 32'd1);
        chk("sb.acc2.wmask", 32'(agu_o_cmd_wmask), 32'h8);
        tick();
        chk("sb.wb.valid", 32'(wbck_o_valid), 32'd1);
        chk("sb.wb.en", 32'(agu_o_cmd_enable), 32'd0);
        chk("sb.wb.flags", {30'd0, wbck_o_rdwen, wbck_o_err}, 32'd0);
        chk("sb.wb.wdata", wbck_o_wdata, 32'd0);
        wbck_i_ready = 1'b1;
        lsu_i_wbck_wdata = 32'd0;
        tick();
        wbck_i_ready = 1'b0;

        // sh to odd address: error after one cycle, no enable
        disp(1'b0, 1'b1, 3'b001, 32'h201, 32'd0, 32'h0000_1234, 5'd3);
        chk("sh.wb.en", 32'(agu_o_cmd_enable), 32'd0);
        chk("sh.wb.valid", 32'(wbck_o_valid), 32'd1);
        chk("sh.wb.flags", {30'd0, wbck_o_rdwen, wbck_o_err}, 32'd1);
        chk("sh.wb.badaddr", wbck_o_badaddr, 32'h201);
        chk("sh.wb.misalgn", 32'(agu_o_cmd_misalgn), 32'd1);
        chk("sh.wb.wdata", wbck_o_wdata, 32'd0);
        wbck_i_ready = 1'b1;
        tick();
        wbck_i_ready = 1'b0;
        chk("sh.idle.ready", 32'(disp_o_ready), 32'd1);

        // lhu to rd=0
        disp(1'b1, 1'b0, 3'b101, 32'h300, 32'd2, 32'd0, 5'd0);
        chk("lhu.acc1.addr", agu_o_cmd_addr, 32'h302);
        chk("lhu.acc1.su", {30'd0, agu_o_cmd_usign, agu_o_cmd_misalgn}, 32'd2);
        chk("lhu.acc1.size", 32'(agu_o_cmd_size), 32'd1);
        tick();
        lsu_i_wbck_wdata = 32'h0000_BEEF;
        tick();
        chk("lhu.wb.wdata", wbck_o_wdata, 32'h0000_BEEF);
        chk("lhu.wb.flags", {30'd0, wbck_o_rdwen, wbck_o_err}, 32'd0);
        wbck_i_ready = 1'b1;
        tick();
        wbck_i_ready = 1'b0;

        // funct3=011 is illegal even when aligned
        disp(1'b1, 1'b0, 3'b011, 32'h500, 32'd0, 32'd0, 5'd4);
        chk("ill.wb.valid", 32'(wbck_o_valid), 32'd1);
        chk("ill.wb.err", 32'(wbck_o_err), 32'd1);
        chk("ill.wb.badaddr", wbck_o_badaddr, 32'h500);
        wbck_i_ready = 1'b1;
        tick();
        wbck_i_ready = 1'b0;

        // LSU reports an access fault on lw x6, 0(0x600)
        disp(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 32'd0, 5'd6);
        tick();
        lsu_i_wbck_wdata = 32'h5555_AAAA;
        lsu_i_wbck_err = 1'b1;
        tick();
        lsu_i_wbck_err = 1'b0;
        chk("lerr.wb.flags", {30'd0, wbck_o_rdwen, wbck_o_err}, 32'd1);
        chk("lerr.wb.wdata", wbck_o_wdata, 32'd0);
        chk("lerr.wb.badaddr", wbck_o_badaddr, 32'h600);
        wbck_i_ready = 1'b1;
        tick();
        wbck_i_ready = 1'b0;

        // load==store is consumed and dropped
        disp(1'b1, 1'b1, 3'b010, 32'h700, 32'd0, 32'd0, 5'd8);
        chk("both.en", 32'(agu_o_cmd_enable), 32'd0);
        chk("both.valid", 32'(wbck_o_valid), 32'd0);
        chk("both.ready", 32'(disp_o_ready), 32'd1);

        // lb x9, -1(0x1000) then back-pressure on wbck
        disp(1'b1, 1'b0, 3'b000, 32'h1000, 32'hFFFF_FFFF, 32'd0, 5'd9);
        chk("lb.acc1.addr", agu_o_cmd_addr, 32'h0000_0FFF);
        tick();
        lsu_i_wbck_wdata = 32'hFFFF_FF80;
        tick();
        lsu_i_wbck_wdata = 32'd0;
        disp_i_valid = 1'b1; disp_i_load = 1'b0; disp_i_store = 1'b1;
        disp_i_funct3 = 3'b010; disp_i_rs1 = 32'h400; disp_i_imm = 32'd8;
        disp_i_rs2 = 32'hCAFE_BABE; disp_i_rd_idx = 5'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(wbck_o_valid), 32'd1);
            chk("bp.ready", 32'(disp_o_ready), 32'd0);
            chk("bp.wdata", wbck_o_wdata, 32'hFFFF_FF80);
            chk("bp.rd", {26'd0, wbck_o_rdwen, wbck_o_rd_idx}, 32'h29);
            tick();
        end
        chk("bp.last.valid", 32'(wbck_o_valid), 32'd1);
        wbck_i_ready = 1'b1;
        tick();
        wbck_i_ready = 1'b0;
        chk("bp.idle.valid", 32'(wbck_o_valid), 32'd0);
        chk("bp.idle.en", 32'(agu_o_cmd_enable), 32'd0);
        chk("bp.idle.ready", 32'(disp_o_ready), 32'd1);
        tick();
        disp_i_valid = 1'b0;
        chk("sw.acc1.en", 32'(agu_o_cmd_enable), 32'd1);
        chk("sw.acc1.addr", agu_o_cmd_addr, 32'h408);
        chk("sw.acc1.wdata", agu_o_cmd_wdata, 32'hCAFE_BABE);
        chk("sw.acc1.wmask", 32'(agu_o_cmd_wmask), 32'hF);
        tick();
        chk("sw.acc2.en", 32'(agu_o_cmd_enable), 32'd1);

        // reset in ACC2 drops the store
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cleared("midrst");
        wbck_i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst.nowb", {30'd0, wbck_o_valid, agu_o_cmd_enable}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
